// File: rtl/hub_tx_arbiter.sv
//==============================================================================
// Module   : hub_tx_arbiter
// Brief    : Frame-level round-robin scheduler for the shared hub forwarding
//            datapath. It grants one source port at a time and broadcasts that
//            port's bytes to every other port. It also enforces the inter-frame
//            gap and the jabber (maximum frame length) truncation.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module hub_tx_arbiter #(
   parameter int NUM_PORTS  = 3,
   parameter int DATA_W     = 8,
   parameter int IFG_CYCLES = 12,
   parameter int MAX_FRAME  = 1518,
   parameter int LEN_W      = 11
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_PORTS-1:0]          req,
   input  logic [NUM_PORTS*DATA_W-1:0]   src_data,
   input  logic [NUM_PORTS-1:0]          src_valid,
   input  logic [NUM_PORTS-1:0]          src_last,
   output logic [NUM_PORTS-1:0]          src_ready,
   output logic [DATA_W-1:0]             tx_data,
   output logic [NUM_PORTS-1:0]          tx_valid,
   input  logic [NUM_PORTS-1:0]          tx_ready,
   output logic [NUM_PORTS-1:0]          grant,
   output logic                          busy,
   output logic                          frame_done,
   output logic                          jabber_err
);

   localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int IFG_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
   localparam logic [IFG_W-1:0] IFG_LAST  = IFG_W'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
   localparam logic [LEN_W-1:0] LEN_LAST  = LEN_W'(MAX_FRAME - 1);
   localparam logic [PTR_W-1:0] PTR_RESET = PTR_W'(NUM_PORTS - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_GRANT = 3'd1,
      S_XFER  = 3'd2,
      S_DRAIN = 3'd3,
      S_IFG   = 3'd4
   } state_t;

   state_t               state, state_nxt, end_state;
   logic [PTR_W-1:0]     rr_ptr;
   logic [LEN_W-1:0]     byte_cnt;
   logic [IFG_W-1:0]     ifg_cnt;
   logic [PTR_W-1:0]     pick_idx;
   logic [NUM_PORTS-1:0] pick_hot;
   logic                 sel_valid, sel_last;
   logic [DATA_W-1:0]    sel_data;
   logic                 all_rdy, fire, jab_hit;

   assign busy = (state != S_IDLE);

   // Round-robin pick: scan the ports after the last winner, the last winner itself last.
   always_comb begin
      logic             found;
      logic [PTR_W-1:0] cand;
      found    = 1'b0;
      cand     = '0;
      pick_idx = '0;
      pick_hot = '0;
      for (int k = 1; k <= NUM_PORTS; k++) begin
         cand = PTR_W'((int'(rr_ptr) + k) % NUM_PORTS);
         if (!found && req[cand]) begin
            found    = 1'b1;
            pick_idx = cand;
            pick_hot = NUM_PORTS'(1) << cand;
         end
      end
   end

   // Select the owner's FIFO head signals using the one-hot grant.
   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (grant[p]) begin
            sel_valid = src_valid[p];
            sel_last  = src_last[p];
            sel_data  = src_data[p*DATA_W +: DATA_W];
         end
      end
   end

   // Next-state logic and datapath strobes; the owner's own tx bit is never driven.
   always_comb begin
      state_nxt  = state;
      end_state  = (IFG_CYCLES == 0) ? S_IDLE : S_IFG;
      src_ready  = '0;
      tx_valid   = '0;
      tx_data    = '0;
      frame_done = 1'b0;
      jab_hit    = 1'b0;
      fire       = 1'b0;
      all_rdy    = &(tx_ready | grant);
      case (state)
         S_IDLE: begin
            if (|req) state_nxt = S_GRANT;
         end
         S_GRANT: begin
            state_nxt = S_XFER;
         end
         S_XFER: begin
            src_ready = grant & {NUM_PORTS{all_rdy}};
            tx_valid  = ~grant & {NUM_PORTS{sel_valid & all_rdy}};
            tx_data   = sel_data;
            fire      = sel_valid & all_rdy;
            if (fire) begin
               if (sel_last) begin
                  frame_done = 1'b1;
                  state_nxt  = end_state;
               end else if (byte_cnt == LEN_LAST) begin
                  jab_hit   = 1'b1;
                  state_nxt = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            src_ready = grant;
            if (sel_valid && sel_last) begin
               frame_done = 1'b1;
               state_nxt  = end_state;
            end
         end
         S_IFG: begin
            if (ifg_cnt == IFG_LAST) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Grant ownership, round-robin pointer, byte/gap counters and the jabber pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         grant      <= '0;
         rr_ptr     <= PTR_RESET;
         byte_cnt   <= '0;
         ifg_cnt    <= '0;
         jabber_err <= 1'b0;
      end else begin
         jabber_err <= jab_hit;
         if (state == S_IDLE && |req) begin
            grant  <= pick_hot;
            rr_ptr <= pick_idx;
         end
         if (state == S_GRANT) byte_cnt <= '0;
         else if (fire)        byte_cnt <= byte_cnt + LEN_W'(1);
         if (frame_done) begin
            grant   <= '0;
            ifg_cnt <= '0;
         end else if (state == S_IFG) begin
            ifg_cnt <= ifg_cnt + IFG_W'(1);
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_hub_tx_arbiter.sv
//==============================================================================
// Module   : tb_hub_tx_arbiter
// Brief    : Scoreboard bench for hub_tx_arbiter. Randomised FIFO sources feed
//            the DUT. A frame-level round-robin model predicts the grant order
//            and the per-destination byte streams, and a monitor checks them.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_hub_tx_arbiter;

   localparam int IFG  = 12;
   localparam int MAXF = 1518;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  req, src_valid, src_last, src_ready, tx_valid, tx_ready, grant;
   logic [23:0] src_data;
   logic [7:0]  tx_data;
   logic        busy, frame_done, jabber_err;

   hub_tx_arbiter #(
      .NUM_PORTS(3), .DATA_W(8), .IFG_CYCLES(IFG), .MAX_FRAME(MAXF), .LEN_W(11)
   ) dut (
      .clk(clk), .reset(reset), .req(req), .src_data(src_data),
      .src_valid(src_valid), .src_last(src_last), .src_ready(src_ready),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .grant(grant), .busy(busy), .frame_done(frame_done), .jabber_err(jabber_err)
   );

   always #5 clk = ~clk;

   // source FIFOs ({last,data}), model-side frame copies, expectations
   logic [8:0] src_q[3][$];
   logic [7:0] fb[3][$];
   int         pf[3][$];
   logic [7:0] exp_q[3][$];
   logic [2:0] exp_grant[$];
   int         exp_lim[$];

   int errors = 0, checks = 0;
   int vprob = 100, rprob = 100;
   bit mon_en = 1'b0;
   int last_winner = 2;
   int exp_done = 0, exp_jab = 0, done_cnt = 0, jab_cnt = 0;
   logic [2:0] prev_grant = '0, cur_g = '0;
   int cur_fwd = 0, cur_lim = 0, gap = 0;
   bit in_gap = 1'b0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add_frame(input int p, input int len);
      logic [7:0] b;
      for (int i = 0; i < len; i++) begin
         b = 8'($urandom);
         src_q[p].push_back({(i == len - 1), b});
         fb[p].push_back(b);
      end
      pf[p].push_back(len);
   endtask

   // Frame-level model: serve queued frames round-robin after the previous
   // winner; truncated frames forward only their first MAXF bytes.
   task automatic plan();
      int w, c, len, lim;
      logic [7:0] b;
      while (pf[0].size() + pf[1].size() + pf[2].size() > 0) begin
         w = -1;
         for (int k = 1; k <= 3; k++) begin
            c = (last_winner + k) % 3;
            if (w < 0 && pf[c].size() > 0) w = c;
         end
         last_winner = w;
         len = pf[w].pop_front();
         lim = (len > MAXF) ? MAXF : len;
         exp_grant.push_back(3'(1 << w));
         exp_lim.push_back(lim);
         exp_done++;
         if (len > MAXF) exp_jab++;
         for (int i = 0; i < len; i++) begin
            b = fb[w].pop_front();
            if (i < lim)
               for (int d = 0; d < 3; d++) if (d != w) exp_q[d].push_back(b);
         end
      end
   endtask

   task automatic go();
      @(negedge clk); #2;
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while (n < budget && !(src_q[0].size() == 0 && src_q[1].size() == 0 && src_q[2].size() == 0 &&
             exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0 &&
             exp_grant.size() == 0 && !busy && !in_gap)) begin
         @(negedge clk); #4;
         n++;
      end
      chk("phase_timeout", (n < budget), 1);
      chk("frame_done_cnt", done_cnt, exp_done);
      chk("jabber_cnt", jab_cnt, exp_jab);
   endtask

   // Source / sink driver: drive on negedge, record pops just before posedge.
   initial begin
      forever begin
         @(negedge clk);
         for (int p = 0; p < 3; p++) begin
            req[p] = (src_q[p].size() > 0);
            if (src_q[p].size() > 0 && $urandom_range(99) < vprob) begin
               src_valid[p]         = 1'b1;
               src_last[p]          = src_q[p][0][8];
               src_data[8*p +: 8]   = src_q[p][0][7:0];
            end else begin
               src_valid[p]         = 1'b0;
               src_last[p]          = 1'($urandom);
               src_data[8*p +: 8]   = 8'($urandom);
            end
            tx_ready[p] = ($urandom_range(99) < rprob);
         end
         #4;
         for (int p = 0; p < 3; p++)
            if (src_valid[p] && src_ready[p] && src_q[p].size() > 0) src_q[p].delete(0);
      end
   end

   // Monitor: grant order, broadcast bytes/mask, stall behaviour, frame length, gap.
   initial begin
      logic [2:0] m;
      forever begin
         @(negedge clk); #4;
         if (mon_en) begin
            if (grant != 0 && prev_grant == 0) begin
               if (exp_grant.size() == 0) chk("grant_unexpected", grant, 0);
               else begin
                  cur_g   = exp_grant.pop_front();
                  cur_lim = exp_lim.pop_front();
                  cur_fwd = 0;
                  chk("grant", grant, cur_g);
               end
            end
            if (grant != 0 && cur_fwd < cur_lim && ((tx_ready | cur_g) != 3'b111))
               chk("stall", {src_ready, tx_valid}, 0);
            if (tx_valid != 0) begin
               m = ~cur_g;
               chk("tx_mask", tx_valid, m);
               cur_fwd++;
               for (int d = 0; d < 3; d++) begin
                  if (tx_valid[d]) begin
                     if (exp_q[d].size() == 0) chk("tx_extra", 1, 0);
                     else chk("tx_data", tx_data, exp_q[d].pop_front());
                  end
               end
            end
            if (frame_done) begin
               done_cnt++;
               chk("frame_len", cur_fwd, cur_lim);
               in_gap = 1'b1;
               gap    = 0;
            end else if (in_gap) begin
               if (busy && grant == 0) gap++;
               else begin
                  chk("ifg_len", gap, IFG);
                  in_gap = 1'b0;
               end
            end
            if (jabber_err) jab_cnt++;
            prev_grant = grant;
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, n, nf, len;
      reset = 1'b0; req = '0; src_valid = '0; src_last = '0; src_data = '0; tx_ready = '0;

      // reset state
      @(negedge clk); #4;
      chk("rst_grant", grant, 0);
      chk("rst_busy", busy, 0);
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_src_ready", src_ready, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_jabber", jabber_err, 0);
      chk("rst_tx_data", tx_data, 0);
      go(); reset = 1'b1;
      go();
      chk("idle_busy", busy, 0);

      // single 64-byte frame from port 0, full rate, with request latency
      vprob = 100; rprob = 100;
      go(); add_frame(0, 64); plan(); mon_en = 1'b1;
      lat = -1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #4;
         if (lat < 0 && tx_valid != 0) lat = i;
      end
      chk("req_to_byte_latency", lat, 2);
      wait_done(500);

      // all ports requesting, 8-byte frames
      go(); add_frame(0, 8); add_frame(0, 8); add_frame(1, 8); add_frame(2, 8); plan();
      wait_done(1000);

      // port 1 100-byte frame under random backpressure and source gaps
      vprob = 80; rprob = 70;
      go(); add_frame(1, 100); plan();
      wait_done(3000);

      // jabber: 1600 bytes from port 2
      vprob = 90; rprob = 90;
      go(); add_frame(2, 1600); plan();
      wait_done(6000);

      // reset mid-frame, then fresh arbitration with req=011
      mon_en = 1'b0; vprob = 100; rprob = 100;
      go(); add_frame(0, 60); fb[0].delete(); pf[0].delete();
      n = 0;
      while (src_q[0].size() > 30 && n < 200) begin @(negedge clk); #4; n++; end
      chk("rst_reach_byte30", (n < 200), 1);
      go(); reset = 1'b0; #1;
      chk("midrst_grant", grant, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_tx_valid", tx_valid, 0);
      chk("midrst_src_ready", src_ready, 0);
      for (int p = 0; p < 3; p++) begin src_q[p].delete(); fb[p].delete(); pf[p].delete(); end
      go(); go(); reset = 1'b1;
      last_winner = 2; prev_grant = '0; in_gap = 1'b0;
      add_frame(0, 10); add_frame(1, 10); plan(); mon_en = 1'b1;
      wait_done(1000);

      // random traffic, including single-byte frames
      vprob = 70; rprob = 75;
      for (int r = 0; r < 6; r++) begin
         go();
         nf = 0;
         for (int p = 0; p < 3; p++) begin
            for (int f = 0; f < int'($urandom_range(0, 2)); f++) begin
               len = ($urandom_range(0, 3) == 0) ? 1 : int'($urandom_range(2, 40));
               add_frame(p, len);
               nf++;
            end
         end
         if (nf == 0) add_frame(r % 3, 1);
         plan();
         wait_done(4000);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
